// File: rtl/uart_axil_arb_pkg.sv
// Shared types and constants for the UART AXI4-Lite arbiter.
package uart_axil_arb_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StWb,
    StRa,
    StRd
  } arb_state_e;

  localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/uart_axil_arbiter_if.sv
// AXI4-Lite register-port bundle; master drives requests, slave drives responses.
interface uart_axil_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 13,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/uart_axil_arb_mux.sv
// Combinational 2:1 channel steering between two requesters and the shared port.
// Each channel only passes when its enable is set; everything else reads as 0.
module uart_axil_arb_mux
  import uart_axil_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 13,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                grant_id,
  input  logic                en_aw,
  input  logic                en_w,
  input  logic                en_b,
  input  logic                en_ar,
  input  logic                en_r,
  uart_axil_arbiter_if.slave  s0_axi,
  uart_axil_arbiter_if.slave  s1_axi,
  uart_axil_arbiter_if.master m_axi
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] sel_awaddr;
  logic                  sel_awvalid;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [STRB_WIDTH-1:0] sel_wstrb;
  logic                  sel_wvalid;
  logic                  sel_bready;
  logic [ADDR_WIDTH-1:0] sel_araddr;
  logic                  sel_arvalid;
  logic                  sel_rready;

  // Pick the granted requester's request-side signals.
  always_comb begin
    sel_awaddr  = grant_id ? s1_axi.awaddr  : s0_axi.awaddr;
    sel_awvalid = grant_id ? s1_axi.awvalid : s0_axi.awvalid;
    sel_wdata   = grant_id ? s1_axi.wdata   : s0_axi.wdata;
    sel_wstrb   = grant_id ? s1_axi.wstrb   : s0_axi.wstrb;
    sel_wvalid  = grant_id ? s1_axi.wvalid  : s0_axi.wvalid;
    sel_bready  = grant_id ? s1_axi.bready  : s0_axi.bready;
    sel_araddr  = grant_id ? s1_axi.araddr  : s0_axi.araddr;
    sel_arvalid = grant_id ? s1_axi.arvalid : s0_axi.arvalid;
    sel_rready  = grant_id ? s1_axi.rready  : s0_axi.rready;
  end

  // Gate the selected request signals onto the master port.
  always_comb begin
    m_axi.awaddr  = en_aw ? sel_awaddr : '0;
    m_axi.awvalid = en_aw & sel_awvalid;
    m_axi.wdata   = en_w ? sel_wdata : '0;
    m_axi.wstrb   = en_w ? sel_wstrb : '0;
    m_axi.wvalid  = en_w & sel_wvalid;
    m_axi.bready  = en_b & sel_bready;
    m_axi.araddr  = en_ar ? sel_araddr : '0;
    m_axi.arvalid = en_ar & sel_arvalid;
    m_axi.rready  = en_r & sel_rready;
  end

  // Route responses to the granted requester only; the other one sees all zeros.
  always_comb begin
    s0_axi.awready = 1'b0;
    s0_axi.wready  = 1'b0;
    s0_axi.bresp   = RESP_OKAY;
    s0_axi.bvalid  = 1'b0;
    s0_axi.arready = 1'b0;
    s0_axi.rdata   = '0;
    s0_axi.rresp   = RESP_OKAY;
    s0_axi.rvalid  = 1'b0;
    s1_axi.awready = 1'b0;
    s1_axi.wready  = 1'b0;
    s1_axi.bresp   = RESP_OKAY;
    s1_axi.bvalid  = 1'b0;
    s1_axi.arready = 1'b0;
    s1_axi.rdata   = '0;
    s1_axi.rresp   = RESP_OKAY;
    s1_axi.rvalid  = 1'b0;
    if (grant_id) begin
      s1_axi.awready = en_aw & m_axi.awready;
      s1_axi.wready  = en_w & m_axi.wready;
      s1_axi.bresp   = en_b ? m_axi.bresp : RESP_OKAY;
      s1_axi.bvalid  = en_b & m_axi.bvalid;
      s1_axi.arready = en_ar & m_axi.arready;
      s1_axi.rdata   = en_r ? m_axi.rdata : '0;
      s1_axi.rresp   = en_r ? m_axi.rresp : RESP_OKAY;
      s1_axi.rvalid  = en_r & m_axi.rvalid;
    end else begin
      s0_axi.awready = en_aw & m_axi.awready;
      s0_axi.wready  = en_w & m_axi.wready;
      s0_axi.bresp   = en_b ? m_axi.bresp : RESP_OKAY;
      s0_axi.bvalid  = en_b & m_axi.bvalid;
      s0_axi.arready = en_ar & m_axi.arready;
      s0_axi.rdata   = en_r ? m_axi.rdata : '0;
      s0_axi.rresp   = en_r ? m_axi.rresp : RESP_OKAY;
      s0_axi.rvalid  = en_r & m_axi.rvalid;
    end
  end

endmodule

// File: rtl/uart_axil_arbiter.sv
// Round-robin two-requester AXI4-Lite arbiter in front of the UART register port.
// One whole transaction is granted at a time; the FSM lives here, steering in the mux.
module uart_axil_arbiter
  import uart_axil_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 13,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                chipset_clk,
  input  logic                chipset_rst,
  uart_axil_arbiter_if.slave  s0_axi,
  uart_axil_arbiter_if.slave  s1_axi,
  uart_axil_arbiter_if.master m_axi,
  output logic                grant_id,
  output logic                busy
);

  arb_state_e state_q;
  logic       grant_q;
  logic       rr_last_q;
  logic       aw_done_q;
  logic       w_done_q;

  logic req0, req1, pick, pick_wr;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic en_aw, en_w, en_b, en_ar, en_r;

  // Arbitration choice and master-side handshakes.
  always_comb begin
    req0    = s0_axi.awvalid | s0_axi.arvalid;
    req1    = s1_axi.awvalid | s1_axi.arvalid;
    // On a tie, serve whoever was not served last.
    pick    = (req0 & req1) ? ~rr_last_q : req1;
    pick_wr = pick ? s1_axi.awvalid : s0_axi.awvalid;
    aw_hs   = m_axi.awvalid & m_axi.awready;
    w_hs    = m_axi.wvalid & m_axi.wready;
    b_hs    = m_axi.bvalid & m_axi.bready;
    ar_hs   = m_axi.arvalid & m_axi.arready;
    r_hs    = m_axi.rvalid & m_axi.rready;
  end

  // Channel enables decoded from registered state; done channels stop forwarding.
  always_comb begin
    en_aw = (state_q == StWr) & ~aw_done_q;
    en_w  = (state_q == StWr) & ~w_done_q;
    en_b  = (state_q == StWb);
    en_ar = (state_q == StRa);
    en_r  = (state_q == StRd);
  end

  // Transaction FSM with round-robin pointer and sticky write-channel flags.
  always_ff @(posedge chipset_clk) begin
    if (chipset_rst) begin
      state_q   <= StIdle;
      grant_q   <= 1'b0;
      rr_last_q <= 1'b1;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          aw_done_q <= 1'b0;
          w_done_q  <= 1'b0;
          if (req0 | req1) begin
            grant_q <= pick;
            state_q <= pick_wr ? StWr : StRa;
          end
        end
        StWr: begin
          if (aw_hs) aw_done_q <= 1'b1;
          if (w_hs) w_done_q <= 1'b1;
          if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) state_q <= StWb;
        end
        StWb: begin
          if (b_hs) begin
            state_q   <= StIdle;
            rr_last_q <= grant_q;
          end
        end
        StRa: begin
          if (ar_hs) state_q <= StRd;
        end
        StRd: begin
          if (r_hs) begin
            state_q   <= StIdle;
            rr_last_q <= grant_q;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign grant_id = grant_q;
  assign busy     = (state_q != StIdle);

  uart_axil_arb_mux #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mux (
    .grant_id(grant_q),
    .en_aw   (en_aw),
    .en_w    (en_w),
    .en_b    (en_b),
    .en_ar   (en_ar),
    .en_r    (en_r),
    .s0_axi  (s0_axi),
    .s1_axi  (s1_axi),
    .m_axi   (m_axi)
  );

endmodule
